// File: rtl/shift_add_mult_controller.sv
// Sequencing FSM for a shift-add multiplier: it issues load/add/shift/done strobes
// to an external datapath and tracks which multiplier bit is being processed.
module shift_add_mult_controller #(
    parameter int Word_Length = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           multiplier_lsb,
    output logic                           ready,
    output logic                           busy,
    output logic                           load_en,
    output logic                           add_en,
    output logic                           shift_en,
    output logic                           done,
    output logic [$clog2(Word_Length)-1:0] bit_index
);

    localparam int IW = $clog2(Word_Length);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_EVAL  = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_SHIFT = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [IW-1:0] LAST_INDEX = IW'(Word_Length - 1);

    logic [2:0]    r_state;
    logic [2:0]    w_state_next;
    logic [IW-1:0] r_bit_index;
    logic [IW-1:0] w_bit_index_next;
    logic          w_in_operation;

    // Abort only cancels the working states; DONE has already committed its pulse.
    assign w_in_operation = (r_state == S_LOAD) || (r_state == S_EVAL) ||
                            (r_state == S_ADD)  || (r_state == S_SHIFT);

    always_comb begin
        w_state_next     = S_IDLE;
        w_bit_index_next = r_bit_index;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_next = S_LOAD;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_LOAD: begin
                w_state_next     = S_EVAL;
                w_bit_index_next = '0;
            end
            S_EVAL: begin
                w_state_next = multiplier_lsb ? S_ADD : S_SHIFT;
            end
            S_ADD: begin
                w_state_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_bit_index == LAST_INDEX) begin
                    w_state_next     = S_DONE;
                    w_bit_index_next = '0;
                end else begin
                    w_state_next     = S_EVAL;
                    w_bit_index_next = r_bit_index + 1'b1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next     = S_IDLE;
                w_bit_index_next = '0;
            end
        endcase

        if (abort && w_in_operation) begin
            w_state_next     = S_IDLE;
            w_bit_index_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bit_index <= '0;
        end else begin
            r_state     <= w_state_next;
            r_bit_index <= w_bit_index_next;
        end
    end

    // Pure decodes of the state register; unused encodings drive no strobes.
    assign ready     = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign load_en   = (r_state == S_LOAD);
    assign add_en    = (r_state == S_ADD);
    assign shift_en  = (r_state == S_SHIFT);
    assign done      = (r_state == S_DONE);
    assign bit_index = r_bit_index;

endmodule

// File: tb/tb_shift_add_mult_controller.sv
// Directed bench: a behavioural shift-add datapath answers the controller's strobes,
// and products, latencies and strobe patterns are compared with hand-computed values.
module tb_shift_add_mult_controller;

    localparam int W  = 8;
    localparam int IW = $clog2(W);
    localparam logic [5:0] OUT_IDLE = 6'b100000;  // {ready,busy,load,add,shift,done}
    localparam logic [5:0] OUT_LOAD = 6'b011000;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          multiplier_lsb;
    logic          ready;
    logic          busy;
    logic          load_en;
    logic          add_en;
    logic          shift_en;
    logic          done;
    logic [IW-1:0] bit_index;
    logic [5:0]    outs;

    int n_checks = 0;
    int n_errors = 0;

    logic [2*W-1:0] dp_mcand;
    logic [2*W-1:0] dp_acc;
    logic [W-1:0]   dp_mplier;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;

    shift_add_mult_controller #(.Word_Length(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .multiplier_lsb (multiplier_lsb),
        .ready          (ready),
        .busy           (busy),
        .load_en        (load_en),
        .add_en         (add_en),
        .shift_en       (shift_en),
        .done           (done),
        .bit_index      (bit_index)
    );

    always #5 clk = ~clk;

    assign outs = {ready, busy, load_en, add_en, shift_en, done};

    always @(posedge clk) begin
        if (load_en) begin
            dp_mcand  <= {{W{1'b0}}, op_a};
            dp_mplier <= op_b;
            dp_acc    <= '0;
        end else begin
            if (add_en) dp_acc <= dp_acc + dp_mcand;
            if (shift_en) begin
                dp_mcand  <= dp_mcand << 1;
                dp_mplier <= dp_mplier >> 1;
            end
        end
    end

    assign multiplier_lsb = dp_mplier[0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start at edge k, then follow the operation until done; exp_cyc is done's offset from k.
    task automatic run_mult(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int exp_cyc, input logic [2*W-1:0] exp_prod);
        int         n;
        int         adds;
        int         shifts;
        int         excl_bad;
        int         follow_bad;
        logic       prev_add;
        logic [W-1:0] mask;
        n = 1; adds = 0; shifts = 0; excl_bad = 0; follow_bad = 0;
        prev_add = 1'b0; mask = '0;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_load"}, 32'(outs), 32'(OUT_LOAD));
        while (!done && n < 200) begin
            tick();
            n++;
            if (add_en) begin
                adds++;
                mask[bit_index] = 1'b1;
            end
            if (shift_en) shifts++;
            if (prev_add && !shift_en) follow_bad++;
            prev_add = add_en;
            if ($countones({load_en, add_en, shift_en, done}) > 1) excl_bad++;
        end
        chk({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
        chk({tag, "_product"}, 32'(dp_acc), 32'(exp_prod));
        chk({tag, "_addmask"}, 32'(mask), 32'(b));
        chk({tag, "_shifts"}, 32'(shifts), 32'(W));
        chk({tag, "_excl"}, 32'(excl_bad), 32'd0);
        chk({tag, "_add_then_shift"}, 32'(follow_bad), 32'd0);
        tick();
        chk({tag, "_idle_after"}, 32'(outs), 32'(OUT_IDLE));
        $display("txn %s: 0x%02h * 0x%02h -> 0x%04h, done at k+%0d, %0d adds",
                 tag, a, b, dp_acc, n, adds);
    endtask

    initial begin
        int n;
        int dcount;
        int load_cyc[$];
        int done_cyc[$];
        int exp_load[3];
        int exp_done[2];

        reset = 1'b1; start = 1'b1; abort = 1'b1;
        op_a = '0; op_b = '0;
        repeat (3) tick();
        chk("reset_outs", 32'(outs), 32'(OUT_IDLE));
        chk("reset_idx", 32'(bit_index), 32'd0);
        reset = 1'b0; start = 1'b0; abort = 1'b0;

        run_mult("mul_00", 8'h07, 8'h00, 18, 16'h0000);
        run_mult("mul_ff", 8'hFF, 8'hFF, 26, 16'hFE01);
        run_mult("mul_a5", 8'h03, 8'hA5, 22, 16'h01EF);

        // Abort while adding bit 3
        op_a = 8'h11; op_b = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(add_en && bit_index == 3) && n < 100) begin
            tick();
            n++;
        end
        chk("abort_reach_add", 32'(add_en), 32'd1);
        chk("abort_reach_idx", 32'(bit_index), 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_outs", 32'(outs), 32'(OUT_IDLE));
        chk("abort_idx", 32'(bit_index), 32'd0);
        dcount = 0;
        repeat (25) begin
            tick();
            dcount += int'(done);
        end
        chk("abort_no_done", 32'(dcount), 32'd0);
        $display("txn abort: cancelled at bit 3 in ADD");
        run_mult("after_abort", 8'h05, 8'h0B, 21, 16'h0037);

        // Abort in IDLE beats start, and alone does nothing
        start = 1'b1; abort = 1'b1;
        tick();
        chk("idle_abort_start", 32'(outs), 32'(OUT_IDLE));
        start = 1'b0;
        tick();
        chk("idle_abort_only", 32'(outs), 32'(OUT_IDLE));
        abort = 1'b0;
        $display("txn idle_abort: start suppressed");

        // Start held high: 18-cycle operations with one IDLE cycle between them
        op_a = 8'h09; op_b = 8'h00;
        start = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            tick();
            if (load_en) load_cyc.push_back(c);
            if (done) done_cyc.push_back(c);
            if (c == 19) chk("b2b_idle_gap1", 32'(outs), 32'(OUT_IDLE));
            if (c == 38) chk("b2b_idle_gap2", 32'(outs), 32'(OUT_IDLE));
        end
        start = 1'b0;
        exp_load = '{1, 20, 39};
        exp_done = '{18, 37};
        chk("b2b_nloads", 32'(load_cyc.size()), 32'd3);
        chk("b2b_ndones", 32'(done_cyc.size()), 32'd2);
        for (int i = 0; i < 3; i++)
            chk($sformatf("b2b_load%0d", i),
                32'(load_cyc.size() > i ? load_cyc[i] : -1), 32'(exp_load[i]));
        for (int i = 0; i < 2; i++)
            chk($sformatf("b2b_done%0d", i),
                32'(done_cyc.size() > i ? done_cyc[i] : -1), 32'(exp_done[i]));
        n = 0;
        while (!ready && n < 50) begin
            tick();
            n++;
        end
        chk("b2b_drain", 32'(ready), 32'd1);
        $display("txn back_to_back: loads=%0d dones=%0d", load_cyc.size(), done_cyc.size());

        // Reset in SHIFT at bit 5, with start and abort asserted alongside
        op_a = 8'h22; op_b = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(shift_en && bit_index == 5) && n < 100) begin
            tick();
            n++;
        end
        chk("rst_mid_reach_idx", 32'(bit_index), 32'd5);
        reset = 1'b1; start = 1'b1; abort = 1'b1;
        tick();
        chk("rst_mid_outs", 32'(outs), 32'(OUT_IDLE));
        chk("rst_mid_idx", 32'(bit_index), 32'd0);
        tick();
        chk("rst_hold_outs", 32'(outs), 32'(OUT_IDLE));
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        $display("txn mid_reset: reset in SHIFT at bit 5");
        run_mult("post_reset", 8'h0D, 8'h0C, 20, 16'h009C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shift_add_mult_controller.md
SHIFT_ADD_MULT_CONTROLLER -- requirements
Module: shift_add_mult_controller

Interface
REQ-001 Parameter: Word_Length, default 8, operand width in bits and number of shift-add iterations; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin one multiplication; accepted only when ready=1.
REQ-005 abort  input  1  cancels the operation in progress; returns the block to IDLE.
REQ-006 multiplier_lsb  input  1  current LSB of the datapath multiplier register.
REQ-007 ready  output  1  high only in IDLE; block can accept start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 load_en  output  1  datapath strobe: load operands, clear accumulator.
REQ-010 add_en  output  1  datapath strobe: accumulator += multiplicand.
REQ-011 shift_en  output  1  datapath strobe: shift multiplicand left and multiplier right.
REQ-012 done  output  1  one-cycle pulse: product in datapath is final.
REQ-013 bit_index  output  $clog2(Word_Length)  index of the multiplier bit currently being processed.

Function
REQ-014 All outputs shall be Moore decodes of registered state; no input shall reach an output combinationally.
REQ-015 States shall be IDLE, LOAD, EVAL, ADD, SHIFT, DONE.
REQ-016 IDLE shall go to LOAD when start=1 and abort=0; otherwise it shall remain in IDLE.
REQ-017 LOAD shall last 1 cycle with load_en=1, set bit_index to 0, and go to EVAL.
REQ-018 EVAL shall last 1 cycle with all strobes 0, sample multiplier_lsb, and go to ADD if it is 1 and to SHIFT if it is 0.
REQ-019 ADD shall last 1 cycle with add_en=1 and go to SHIFT.
REQ-020 SHIFT shall last 1 cycle with shift_en=1.
  - If bit_index = Word_Length-1, it shall go to DONE and bit_index shall wrap to 0.
  - Otherwise it shall increment bit_index and go to EVAL.
REQ-021 DONE shall last 1 cycle with done=1 and go to IDLE unconditionally.
REQ-022 load_en, add_en, shift_en and done shall be mutually exclusive.
REQ-023 Latency: if start is accepted at edge k, done shall be high in cycle k + 2 + 2*Word_Length + p, where p is the popcount of the multiplier.
  - Cycle k+1 is LOAD.
REQ-024 Throughput: a new start shall be accepted no earlier than the edge that ends the DONE cycle plus one, so one IDLE cycle always separates operations.
REQ-025 start while busy=1 shall be ignored and not queued.
REQ-026 abort=1 in any non-IDLE state shall move the state to IDLE at the next edge.
  - done shall not pulse for that operation.
  - bit_index shall go to 0.
REQ-027 abort has priority over start.
  - abort=1 in IDLE with start=1 shall leave the block in IDLE.
  - abort=1 in IDLE with start=0 shall have no effect.
REQ-028 abort sampled during the DONE cycle shall have no effect; the done pulse has already been issued.
REQ-029 Illegal state encodings shall recover to IDLE on the next edge with all strobes 0.

Reset
REQ-030 reset=1 at a rising edge shall force state=IDLE and bit_index=0, overriding start and abort.
  - ready=1, busy=0, load_en=0, add_en=0, shift_en=0, done=0.
REQ-031 reset asserted mid-operation (any state) shall take effect at the next edge with no done pulse.
REQ-032 After reset deasserts, start shall be accepted at the first edge at which start=1.

Verification
REQ-033 Word_Length=8, multiplier 0x00, start pulsed at edge k -> no add_en ever, 8 shift_en pulses, done high in cycle k+18, ready in cycle k+19.
REQ-034 Word_Length=8, multiplier 0xFF -> 8 add_en pulses, each directly followed by shift_en, done in cycle k+26; datapath product 0xFF*0xFF = 0xFE01.
REQ-035 Word_Length=8, multiplier 0xA5 -> add_en at bit_index 0, 2, 5, 7, done in cycle k+22; with multiplicand 0x03 the product is 0x01EF.
REQ-036 abort asserted at bit_index=3 in ADD -> IDLE next edge, done never pulses, and the next start runs a full correct multiplication.
REQ-037 start held high continuously -> operations back-to-back, each separated by exactly one IDLE cycle, and start ignored while busy.
REQ-038 reset pulsed in SHIFT with bit_index=5 -> next cycle all outputs are at their reset values, and start/abort asserted together with reset are ignored.
